// File: rtl/pcie_fifo_rd_sched_pkg.sv
// Shared definitions for the FIFO-to-PCIe read scheduler: FSM encoding,
// default frame/burst geometry and the burst length helper.
package pcie_fifo_rd_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_XFER,
      ST_END
   } state_t;

   localparam int          DEF_FRAME_WORDS = 115200;
   localparam int          DEF_BURST_WORDS = 16;
   localparam logic [31:0] BYTES_PER_WORD  = 32'd16;

   // Words in the next burst: a full burst, or whatever remains of the frame.
   function automatic logic [8:0] burst_len(input logic [16:0] fcnt,
                                            input int unsigned burst,
                                            input int unsigned frame);
      int unsigned rem;
      rem = frame - 32'(fcnt);
      return 9'((rem < burst) ? rem : burst);
   endfunction

endpackage

// File: rtl/pcie_fifo_skid_buf.sv
// Two-entry in-order output buffer between the FIFO read port and TX.
module pcie_fifo_skid_buf #(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] head, tail;
   logic              push, pop;

   assign out_valid = (count != 2'd0);
   assign in_ready  = (count != 2'd2) || out_ready;
   assign out_data  = head;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= in_data;
               else               tail <= in_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= in_data;
               end else begin
                  head <= tail;
                  tail <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pcie_fifo_rd_sched.sv
// Reads video words from a FIFO and issues them to the host as PCIe DMA
// bursts, walking a frame buffer and wrapping at the end of each frame.
module pcie_fifo_rd_sched
   import pcie_fifo_rd_sched_pkg::*;
#(
   parameter int DATA_W      = 128,
   parameter int LVL_W       = 10,
   parameter int BURST_WORDS = DEF_BURST_WORDS,
   parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
   input  logic              rd_clk,
   input  logic              rd_rst_n,
   input  logic              enable,
   input  logic [31:0]       base_addr,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_rd_empty,
   input  logic [LVL_W:0]    fifo_rd_water_level,
   output logic              dma_req,
   input  logic              dma_gnt,
   output logic [31:0]       dma_addr,
   output logic [8:0]        dma_len,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              frame_done,
   output logic              busy
);

   state_t      state, state_nxt;
   logic [16:0] frame_cnt, frame_sum;
   logic [8:0]  cur_len, issued, sent;
   logic        in_flight, consume, buf_ready, wrap;
   logic [1:0]  buf_cnt, occ;

   assign consume   = tx_valid && tx_ready;
   // Occupancy once this cycle's pop lands, net of the word leaving now;
   // keeps the buffer bounded at 2 while sustaining one word per cycle.
   assign occ       = 2'(in_flight) + buf_cnt - 2'(consume);
   assign frame_sum = frame_cnt + 17'(cur_len);
   assign wrap      = (int'(frame_sum) == FRAME_WORDS);

   assign dma_req  = (state == ST_REQ);
   assign dma_addr = dma_req ? base_addr + 32'(frame_cnt) * BYTES_PER_WORD : '0;
   assign dma_len  = dma_req ? cur_len : '0;
   assign busy     = (state != ST_IDLE);
   assign tx_last  = tx_valid && (sent == cur_len - 9'd1);

   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         ST_IDLE: if (enable) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!enable)
               state_nxt = ST_IDLE;
            else if (32'(fifo_rd_water_level) >= 32'(cur_len))
               state_nxt = ST_REQ;
         end
         ST_REQ: if (dma_gnt) state_nxt = ST_XFER;
         ST_XFER: begin
            fifo_rd_en = !fifo_rd_empty && (issued < cur_len) && (occ < 2'd2) && buf_ready;
            if (tx_last && tx_ready) state_nxt = ST_END;
         end
         ST_END:  state_nxt = enable ? ST_WAIT : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state      <= ST_IDLE;
         frame_cnt  <= '0;
         cur_len    <= '0;
         issued     <= '0;
         sent       <= '0;
         in_flight  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_flight  <= fifo_rd_en;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: cur_len <= burst_len(frame_cnt, BURST_WORDS, FRAME_WORDS);
            ST_REQ: begin
               issued <= '0;
               sent   <= '0;
            end
            ST_XFER: begin
               issued <= issued + 9'(fifo_rd_en);
               sent   <= sent + 9'(consume);
            end
            ST_END: begin
               if (wrap) begin
                  frame_cnt  <= '0;
                  frame_done <= 1'b1;
                  cur_len    <= burst_len(17'd0, BURST_WORDS, FRAME_WORDS);
               end else begin
                  frame_cnt  <= frame_sum;
                  cur_len    <= burst_len(frame_sum, BURST_WORDS, FRAME_WORDS);
               end
            end
            default: ;
         endcase
      end
   end

   pcie_fifo_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (rd_clk),
      .rst_n     (rd_rst_n),
      .in_valid  (in_flight),
      .in_ready  (buf_ready),
      .in_data   (fifo_rd_data),
      .out_valid (tx_valid),
      .out_ready (tx_ready),
      .out_data  (tx_data),
      .count     (buf_cnt)
   );

endmodule

// File: tb/tb_pcie_fifo_rd_sched.sv
// Bench for pcie_fifo_rd_sched: FIFO model, DMA arbiter and TX sink, with a
// frame/burst reference model checked every cycle.
module tb_pcie_fifo_rd_sched;

   localparam int DATA_W = 128;
   localparam int LVL_W  = 10;
   localparam int BURST  = 16;
   localparam int FRAME  = 40;

   typedef logic [LVL_W:0] lvl_t;

   logic              rd_clk = 1'b0;
   logic              rd_rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [31:0]       base_addr = 32'h1000_0000;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_rd_data = '0;
   logic              fifo_rd_empty = 1'b1;
   lvl_t              fifo_rd_water_level = '0;
   logic              dma_req;
   logic              dma_gnt = 1'b0;
   logic [31:0]       dma_addr;
   logic [8:0]        dma_len;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready = 1'b1;
   logic              tx_last;
   logic              frame_done;
   logic              busy;

   pcie_fifo_rd_sched #(
      .DATA_W      (DATA_W),
      .LVL_W       (LVL_W),
      .BURST_WORDS (BURST),
      .FRAME_WORDS (FRAME)
   ) dut (
      .rd_clk              (rd_clk),
      .rd_rst_n            (rd_rst_n),
      .enable              (enable),
      .base_addr           (base_addr),
      .fifo_rd_en          (fifo_rd_en),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_rd_empty       (fifo_rd_empty),
      .fifo_rd_water_level (fifo_rd_water_level),
      .dma_req             (dma_req),
      .dma_gnt             (dma_gnt),
      .dma_addr            (dma_addr),
      .dma_len             (dma_len),
      .tx_valid            (tx_valid),
      .tx_data             (tx_data),
      .tx_ready            (tx_ready),
      .tx_last             (tx_last),
      .frame_done          (frame_done),
      .busy                (busy)
   );

   always #5 rd_clk = ~rd_clk;

   int tests = 0;
   int fails = 0;

   // Stimulus knobs
   int push_total = 0;
   int rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: random
   int gnt_delay  = 3;
   bit gnt_rand   = 1'b0;

   // FIFO model: one-cycle read latency; every popped word is logged in order
   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] pop_log[$];
   int                pushed = 0;

   always @(posedge rd_clk) begin
      logic [DATA_W-1:0] w;
      if (fifo_rd_en && fq.size() > 0) begin
         w = fq.pop_front();
         fifo_rd_data <= w;
         pop_log.push_back(w);
      end
      while (pushed < push_total) begin
         fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
         pushed++;
      end
      fifo_rd_water_level <= lvl_t'(fq.size());
      fifo_rd_empty       <= (fq.size() == 0);
   end

   always @(posedge rd_clk) begin
      #1;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   int gcnt = 0;
   always @(posedge rd_clk) begin
      #1;
      if (dma_gnt) begin
         dma_gnt = 1'b0;
      end else if (dma_req) begin
         if (gcnt <= 0) dma_gnt = 1'b1;
         else           gcnt--;
      end else begin
         gcnt = gnt_rand ? int'($urandom_range(0, 4)) : gnt_delay;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push(input int n);
      push_total += n;
   endtask

   // Reference model state (owned by the monitor)
   int          cyc = 0, fd_due = -1, fc = 0;
   bit          active = 1'b0;
   int          blen = 0, beat = 0, popped = 0, rd_idx = 0;
   bit          req_prev = 1'b0, gnt_prev = 1'b0, pop_prev = 1'b0;
   int          hs_count = 0, burst_done = 0, nreq = 0, fd_count = 0;
   int          first_cyc = 0, last_cyc = 0, last_beat_no = 0;
   logic [31:0] log_addr[16];
   int          log_len[16];

   task automatic monitor();
      int exp_len, held, buffered;
      logic [31:0] prev_addr;
      logic [8:0]  prev_len;
      forever begin
         @(negedge rd_clk);
         if (!rd_rst_n) begin
            rd_idx   = pop_log.size();
            active   = 1'b0;
            fc       = 0;
            fd_due   = -1;
            req_prev = 1'b0;
            gnt_prev = 1'b0;
            pop_prev = 1'b0;
         end else begin
            cyc++;
            exp_len  = (FRAME - fc < BURST) ? FRAME - fc : BURST;
            held     = pop_log.size() - rd_idx;
            buffered = held - int'(pop_prev);
            check("frame_done", 128'(frame_done), 128'(cyc == fd_due));
            if (frame_done) fd_count++;
            if (active) check("busy_in_burst", 128'(busy), 128'(1));
            if (!busy) check("idle_quiet", 128'({dma_req, tx_valid, fifo_rd_en}), 128'(0));
            check("occupancy_max2", 128'(held <= 2), 128'(1));
            if (req_prev && !gnt_prev)
               check("req_stable", 128'({dma_req, dma_addr, dma_len}), 128'({1'b1, prev_addr, prev_len}));
            if (dma_req) begin
               check("req_addr", 128'(dma_addr), 128'(base_addr + 32'(fc * 16)));
               check("req_len", 128'(dma_len), 128'(exp_len));
               check("req_outside_burst", 128'(active), 128'(0));
               if (dma_gnt) begin
                  active = 1'b1;
                  blen   = exp_len;
                  beat   = 0;
                  popped = 0;
                  if (nreq < 16) begin
                     log_addr[nreq] = dma_addr;
                     log_len[nreq]  = int'(dma_len);
                  end
                  nreq++;
               end
            end
            if (fifo_rd_en) begin
               check("pop_in_burst", 128'(active), 128'(1));
               check("pop_nonempty", 128'(fifo_rd_empty), 128'(0));
               check("pop_count", 128'(popped < blen), 128'(1));
               check("pop_occupancy", 128'(held - int'(tx_valid && tx_ready) < 2), 128'(1));
               popped++;
            end
            check("tx_valid", 128'(tx_valid), 128'(buffered > 0));
            if (tx_valid) begin
               check("tx_in_burst", 128'(active), 128'(1));
               check("tx_last", 128'(tx_last), 128'(beat == blen - 1));
               if (tx_ready) begin
                  if (held > 0) begin
                     check("tx_data", tx_data, pop_log[rd_idx]);
                     rd_idx++;
                  end
                  if (beat == 0) first_cyc = cyc;
                  if (tx_last) last_beat_no = beat + 1;
                  beat++;
                  hs_count++;
                  if (beat == blen) begin
                     active   = 1'b0;
                     last_cyc = cyc;
                     burst_done++;
                     fc += blen;
                     if (fc == FRAME) begin
                        fc     = 0;
                        fd_due = cyc + 2;
                     end
                  end
               end
            end
            pop_prev  = fifo_rd_en;
            req_prev  = dma_req;
            gnt_prev  = dma_gnt;
            prev_addr = dma_addr;
            prev_len  = dma_len;
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctl"}, 128'({fifo_rd_en, dma_req, dma_addr, dma_len, tx_valid,
                                  tx_last, frame_done, busy}), 128'(0));
      check({name, "_data"}, tx_data, 128'(0));
   endtask

   task automatic wait_bursts(input int n, input string name);
      for (int i = 0; i < 600 && burst_done < n; i++) tick();
      check(name, 128'(burst_done >= n), 128'(1));
   endtask

   task automatic wait_hs(input int n, input string name);
      for (int i = 0; i < 600 && hs_count < n; i++) tick();
      check(name, 128'(hs_count >= n), 128'(1));
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 800 && busy; i++) tick();
      check(name, 128'(busy), 128'(0));
   endtask

   initial begin
      int hs0;
      fork
         monitor();
      join_none

      repeat (3) tick();
      check_reset_outputs("reset");
      rd_rst_n = 1'b1;
      tick();

      // Single full burst, level 20, grant delayed, sink always ready
      push(20);
      repeat (2) tick();
      enable = 1'b1;
      wait_bursts(1, "burst1_done");
      check("burst1_addr", 128'(log_addr[0]), 128'(32'h1000_0000));
      check("burst1_len", 128'(log_len[0]), 128'(16));
      check("burst1_back_to_back", 128'(last_cyc - first_cyc), 128'(15));
      check("burst1_last_on_16", 128'(last_beat_no), 128'(16));

      // Level threshold: 15 words must not request, 16 requests next cycle
      rdy_mode = 1;
      push(11);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("no_req_at_15", 128'(dma_req), 128'(0));
      end
      push(1);
      tick();
      check("req_not_before_level", 128'(dma_req), 128'(0));
      tick();
      check("req_after_level16", 128'(dma_req), 128'(1));
      wait_bursts(2, "burst2_done");
      check("burst2_addr", 128'(log_addr[1]), 128'(32'h1000_0100));
      check("burst2_len", 128'(log_len[1]), 128'(16));

      // Short tail burst closes the frame
      rdy_mode = 0;
      push(8);
      wait_bursts(3, "burst3_done");
      check("burst3_addr", 128'(log_addr[2]), 128'(32'h1000_0200));
      check("burst3_len", 128'(log_len[2]), 128'(8));
      repeat (3) tick();
      check("frame_done_pulses", 128'(fd_count), 128'(1));

      // Disable mid-burst: burst still completes, then scheduler idles
      push(16);
      wait_hs(40 + 5, "beat5_reached");
      enable = 1'b0;
      wait_bursts(4, "burst4_done");
      check("burst4_addr_wrapped", 128'(log_addr[3]), 128'(32'h1000_0000));
      check("burst4_beats", 128'(hs_count), 128'(56));
      repeat (4) tick();
      check("idle_after_disable", 128'({busy, dma_req}), 128'(0));

      // Reset in the middle of a transfer
      enable = 1'b1;
      push(16);
      wait_hs(56 + 3, "burst5_started");
      rd_rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_xfer");
      repeat (3) tick();
      rd_rst_n = 1'b1;
      push(16);
      for (int i = 0; i < 100 && nreq < 6; i++) tick();
      check("post_reset_req", 128'(nreq), 128'(6));
      check("post_reset_addr", 128'(log_addr[5]), 128'(32'h1000_0000));
      enable = 1'b0;
      push(16);
      wait_idle("idle_before_random");

      // Randomized traffic with a new base address
      base_addr = $urandom() & 32'hFFFF_FFF0;
      rdy_mode  = 2;
      gnt_rand  = 1'b1;
      enable    = 1'b1;
      hs0       = hs_count;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (fq.size() < 48 && $urandom_range(0, 2) == 0) push(int'($urandom_range(1, 8)));
         if ($urandom_range(0, 199) == 0) enable = ~enable;
      end
      enable = 1'b0;
      push(BURST);
      wait_idle("random_drain_idle");
      check("random_progress", 128'(hs_count > hs0 + 200), 128'(1));

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
